// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// ----------------
// Shares one single-port memory between the instruction and data ports of a
// harvard MIPS CPU. Each CPU cycle's accesses are serialised: the data access
// (if any) goes first, then the instruction fetch (if any). The CPU is held
// through clk_enable until every access it requested has completed. Read
// results are returned on registers that hold until the next read of the
// same kind completes.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   instr_req         - CPU wants an instruction fetch this CPU cycle
//   instr_address     - fetch address (stable while clk_enable=0)
//   instr_readdata    - last fetched word (registered)
//   data_read/write   - CPU data read / write request (both high = write)
//   data_address      - data address (stable while clk_enable=0)
//   data_writedata    - data to write
//   data_readdata     - last data word read (registered)
//   clk_enable        - high when the CPU may commit this cycle
//   mem_address       - shared memory address (holds its value when idle)
//   mem_read/write    - memory strobes, never high together
//   mem_writedata     - memory write data (holds its value when idle)
//   mem_readdata      - memory read data, valid READ_LATENCY cycles after
//                       the read is accepted
//   mem_waitrequest   - memory busy; the current strobe must be held

module mips_mem_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_WAIT,
        I_REQ,
        I_WAIT,
        RELEASE
    } state_t;

    state_t      state, state_next;
    logic [2:0]  count, count_next;
    logic [31:0] addr_hold, wdata_hold;
    logic        data_req;

    assign data_req = data_read | data_write;

    // Strobes and clk_enable are decoded from the state so that they follow
    // an asynchronous reset immediately. Address and write data are driven
    // live from the CPU during a request and otherwise replay the last value
    // put on the bus.
    always_comb begin
        state_next    = state;
        count_next    = count;
        clk_enable    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = addr_hold;
        mem_writedata = wdata_hold;

        case (state)
            IDLE: begin
                clk_enable = !data_req && !instr_req && !reset;
                if (data_req) begin
                    state_next = D_REQ;
                end else if (instr_req) begin
                    state_next = I_REQ;
                end
            end

            D_REQ: begin
                mem_address = data_address;
                // A simultaneous read and write is treated as a write only.
                if (data_write) begin
                    mem_write     = 1'b1;
                    mem_writedata = data_writedata;
                end else begin
                    mem_read = 1'b1;
                end
                if (!mem_waitrequest) begin
                    if (data_write) begin
                        state_next = instr_req ? I_REQ : RELEASE;
                    end else begin
                        state_next = D_WAIT;
                        count_next = 3'(READ_LATENCY);
                    end
                end
            end

            D_WAIT: begin
                count_next = count - 3'd1;
                if (count == 3'd1) begin
                    state_next = instr_req ? I_REQ : RELEASE;
                end
            end

            I_REQ: begin
                mem_address = instr_address;
                mem_read    = 1'b1;
                if (!mem_waitrequest) begin
                    state_next = I_WAIT;
                    count_next = 3'(READ_LATENCY);
                end
            end

            I_WAIT: begin
                count_next = count - 3'd1;
                if (count == 3'd1) begin
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                clk_enable = !reset;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= 3'd0;
            addr_hold      <= 32'd0;
            wdata_hold     <= 32'd0;
            instr_readdata <= 32'd0;
            data_readdata  <= 32'd0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            addr_hold  <= mem_address;
            wdata_hold <= mem_writedata;
            // The last wait cycle is the one in which mem_readdata is valid.
            if (state == D_WAIT && count == 3'd1) begin
                data_readdata <= mem_readdata;
            end
            if (state == I_WAIT && count == 3'd1) begin
                instr_readdata <= mem_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed testbench for mips_mem_arbiter. Two instances are built, one with
// READ_LATENCY=1 and one with READ_LATENCY=3, each with its own small RAM
// model. Both see the same CPU-side stimulus; sel3 picks which one is checked.

module tb_mips_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic        wait_req;
    logic        sel3;

    logic [31:0] instr_readdata1, data_readdata1, mem_address1, mem_writedata1, mem_readdata1;
    logic        clk_enable1, mem_read1, mem_write1;
    logic [31:0] instr_readdata3, data_readdata3, mem_address3, mem_writedata3, mem_readdata3;
    logic        clk_enable3, mem_read3, mem_write3;

    int n_compared   = 0;
    int n_mismatched = 0;

    mips_mem_arbiter #(.READ_LATENCY(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .instr_req      (instr_req),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata1),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata1),
        .clk_enable     (clk_enable1),
        .mem_address    (mem_address1),
        .mem_read       (mem_read1),
        .mem_write      (mem_write1),
        .mem_writedata  (mem_writedata1),
        .mem_readdata   (mem_readdata1),
        .mem_waitrequest(wait_req)
    );

    mips_mem_arbiter #(.READ_LATENCY(3)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .instr_req      (instr_req),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata3),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_address   (data_address),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata3),
        .clk_enable     (clk_enable3),
        .mem_address    (mem_address3),
        .mem_read       (mem_read3),
        .mem_write      (mem_write3),
        .mem_writedata  (mem_writedata3),
        .mem_readdata   (mem_readdata3),
        .mem_waitrequest(wait_req)
    );

    // Observed instance
    logic [31:0] m_addr, instr_rd, data_rd;
    logic        m_read, m_write, ce;
    assign m_addr   = sel3 ? mem_address3    : mem_address1;
    assign m_read   = sel3 ? mem_read3       : mem_read1;
    assign m_write  = sel3 ? mem_write3      : mem_write1;
    assign ce       = sel3 ? clk_enable3     : clk_enable1;
    assign instr_rd = sel3 ? instr_readdata3 : instr_readdata1;
    assign data_rd  = sel3 ? data_readdata3  : data_readdata1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: 16 words, upper half for the boot ROM region (addr[31]=1).
    // Read data appears READ_LATENCY cycles after acceptance; any other
    // cycle shows a junk pattern so that a mistimed capture is visible.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] pipe1 [4];
    logic [31:0] pipe3 [4];

    function automatic logic [3:0] idx(input logic [31:0] a);
        return {a[31], a[4:2]};
    endfunction

    assign mem_readdata1 = pipe1[0];
    assign mem_readdata3 = pipe3[2];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] = 32'd0;
                mem3[i] = 32'd0;
            end
            mem1[8]  = 32'h24020005; mem3[8]  = 32'h24020005;
            mem1[9]  = 32'h00851021; mem3[9]  = 32'h00851021;
            mem1[10] = 32'h8C430010; mem3[10] = 32'h8C430010;
            for (int i = 0; i < 4; i++) begin
                pipe1[i] <= 32'hBAD0BAD0;
                pipe3[i] <= 32'hBAD0BAD0;
            end
        end else begin
            pipe1[0] <= (mem_read1 && !wait_req) ? mem1[idx(mem_address1)] : 32'hBAD0BAD0;
            pipe3[0] <= (mem_read3 && !wait_req) ? mem3[idx(mem_address3)] : 32'hBAD0BAD0;
            for (int i = 1; i < 4; i++) begin
                pipe1[i] <= pipe1[i-1];
                pipe3[i] <= pipe3[i-1];
            end
            if (mem_write1 && !wait_req) mem1[idx(mem_address1)] <= mem_writedata1;
            if (mem_write3 && !wait_req) mem3[idx(mem_address3)] <= mem_writedata3;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-transaction bus observations
    int          n_rd, n_wr, n_rd_ia, first_rd, first_wr;
    logic        overlap;
    logic [31:0] rd_addr, wr_addr, wr_data;

    // Starts at a negedge (cycle 0 = IDLE cycle seeing the request), runs
    // until clk_enable pulses, then drops the request and checks the
    // following idle cycle. Returns the pulse cycle number (-1 on timeout).
    task automatic run_txn(input string name, input logic dr, input logic dw, input logic ir,
                           input logic [31:0] da, input logic [31:0] dwd,
                           input logic [31:0] ia, input int nwait, output int cycles);
        n_rd = 0; n_wr = 0; n_rd_ia = 0; first_rd = -1; first_wr = -1;
        overlap = 1'b0; rd_addr = 32'd0; wr_addr = 32'd0; wr_data = 32'd0;
        data_read = dr; data_write = dw; instr_req = ir;
        data_address = da; data_writedata = dwd; instr_address = ia;
        wait_req = (nwait > 0);
        #1;
        check_value({name, "_stall"}, 32'(ce), 32'd0);
        cycles = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            wait_req = (n <= nwait);
            if (m_read) begin
                n_rd++;
                if (first_rd < 0) begin
                    first_rd = n;
                    rd_addr  = m_addr;
                end
                if (m_addr == ia) n_rd_ia++;
            end
            if (m_write) begin
                n_wr++;
                if (first_wr < 0) begin
                    first_wr = n;
                    wr_addr  = m_addr;
                    wr_data  = sel3 ? mem_writedata3 : mem_writedata1;
                end
            end
            if (m_read && m_write) overlap = 1'b1;
            if (ce) begin
                cycles = n;
                break;
            end
        end
        data_read = 1'b0; data_write = 1'b0; instr_req = 1'b0; wait_req = 1'b0;
        @(negedge clk);
        check_value({name, "_idle_ce"}, 32'(ce), 32'd1);
        $display("txn %s: pulse at +%0d, reads=%0d writes=%0d instr=0x%08h data=0x%08h",
                 name, cycles, n_rd, n_wr, instr_rd, data_rd);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; sel3 = 1'b0; wait_req = 1'b0;
        instr_req = 1'b0; instr_address = 32'd0;
        data_read = 1'b0; data_write = 1'b0; data_address = 32'd0; data_writedata = 32'd0;

        // Reset state
        @(negedge clk);
        check_value("rst_ce",       32'(ce),      32'd0);
        check_value("rst_mem_read", 32'(m_read),  32'd0);
        check_value("rst_mem_write",32'(m_write), 32'd0);
        check_value("rst_mem_addr", m_addr,       32'd0);
        check_value("rst_wdata",    mem_writedata1, 32'd0);
        check_value("rst_instr_rd", instr_rd,     32'd0);
        check_value("rst_data_rd",  data_rd,      32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_idle_ce",  32'(ce),      32'd1);
        $display("txn reset: released");

        // Fetch only
        run_txn("fetch", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'hBFC00000, 0, cyc);
        check_value("fetch_pulse",   32'(cyc),  32'd3);
        check_value("fetch_nrd",     32'(n_rd), 32'd1);
        check_value("fetch_nwr",     32'(n_wr), 32'd0);
        check_value("fetch_addr",    rd_addr,   32'hBFC00000);
        check_value("fetch_instr",   instr_rd,  32'h24020005);
        check_value("fetch_data",    data_rd,   32'd0);

        // Write then fetch
        run_txn("wr_fetch", 1'b0, 1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'hBFC00004, 0, cyc);
        check_value("wrf_pulse",     32'(cyc),      32'd4);
        check_value("wrf_nwr",       32'(n_wr),     32'd1);
        check_value("wrf_nrd",       32'(n_rd),     32'd1);
        check_value("wrf_first_wr",  32'(first_wr), 32'd1);
        check_value("wrf_first_rd",  32'(first_rd), 32'd2);
        check_value("wrf_wr_addr",   wr_addr,       32'h00000010);
        check_value("wrf_wr_data",   wr_data,       32'hDEADBEEF);
        check_value("wrf_mem_word",  mem1[4],       32'hDEADBEEF);
        check_value("wrf_instr",     instr_rd,      32'h00851021);
        check_value("wrf_data",      data_rd,       32'd0);

        // Read then fetch
        run_txn("rd_fetch", 1'b1, 1'b0, 1'b1, 32'h00000010, 32'd0, 32'hBFC00008, 0, cyc);
        check_value("rdf_pulse",     32'(cyc),      32'd5);
        check_value("rdf_nrd",       32'(n_rd),     32'd2);
        check_value("rdf_nwr",       32'(n_wr),     32'd0);
        check_value("rdf_first_rd",  32'(first_rd), 32'd1);
        check_value("rdf_rd_addr",   rd_addr,       32'h00000010);
        check_value("rdf_overlap",   32'(overlap),  32'd0);
        check_value("rdf_data",      data_rd,       32'hDEADBEEF);
        check_value("rdf_instr",     instr_rd,      32'h8C430010);

        // Read and write together: only the write goes out
        run_txn("rd_and_wr", 1'b1, 1'b1, 1'b0, 32'h00000014, 32'h12345678, 32'd0, 0, cyc);
        check_value("rw_pulse",      32'(cyc),  32'd2);
        check_value("rw_nwr",        32'(n_wr), 32'd1);
        check_value("rw_nrd",        32'(n_rd), 32'd0);
        check_value("rw_mem_word",   mem1[5],   32'h12345678);
        check_value("rw_data",       data_rd,   32'hDEADBEEF);
        check_value("rw_instr",      instr_rd,  32'h8C430010);

        // Reset in the middle of D_WAIT
        data_read = 1'b1; instr_req = 1'b1;
        data_address = 32'h00000010; instr_address = 32'hBFC00000;
        @(negedge clk);   // D_REQ
        @(negedge clk);   // D_WAIT
        reset = 1'b1;
        #1;
        check_value("mid_rst_mem_read", 32'(m_read), 32'd0);
        check_value("mid_rst_ce",       32'(ce),     32'd0);
        check_value("mid_rst_data",     data_rd,     32'd0);
        check_value("mid_rst_instr",    instr_rd,    32'd0);
        check_value("mid_rst_addr",     m_addr,      32'd0);
        data_read = 1'b0; instr_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_value("post_rst_ce",      32'(ce),     32'd1);
        check_value("post_rst_data",    data_rd,     32'd0);
        $display("txn mid_reset: ce=%0d data=0x%08h", ce, data_rd);

        // READ_LATENCY=3 with two waitrequest cycles on the fetch
        sel3 = 1'b1;
        run_txn("lat3_wait", 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'hBFC00004, 2, cyc);
        check_value("lat3_pulse",    32'(cyc),     32'd7);
        check_value("lat3_nrd",      32'(n_rd),    32'd3);
        check_value("lat3_held_addr",32'(n_rd_ia), 32'd3);
        check_value("lat3_nwr",      32'(n_wr),    32'd0);
        check_value("lat3_instr",    instr_rd,     32'h00851021);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port memory between the harvard CPU's instruction port and data port.
- Serialises each CPU cycle's accesses in a fixed order: data access first, then instruction fetch.
- Returns both results on held registers.
- Stalls the CPU through clk_enable until every access requested in that CPU cycle has completed.
- Sits between mips_cpu_harvard and the unified RAM model used in system-level benches.

Parameters:
- READ_LATENCY, 1, cycles from read acceptance (mem_read=1 and mem_waitrequest=0) to mem_readdata valid; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_req  input  1  CPU requests an instruction fetch this CPU cycle.
- instr_address  input  32  fetch address; held stable while clk_enable=0.
- instr_readdata  output  32  fetched word, registered, held until the next fetch completes.
- data_read  input  1  CPU data read request.
- data_write  input  1  CPU data write request.
- data_address  input  32  data address; held stable while clk_enable=0.
- data_writedata  input  32  write data.
- data_readdata  output  32  read word, registered, held until the next data read completes.
- clk_enable  output  1  CPU advance enable; high means the CPU may commit this cycle.
- mem_address  output  32  shared memory address.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_writedata  output  32  memory write data.
- mem_readdata  input  32  memory read data.
- mem_waitrequest  input  1  memory busy; the current strobe must be held.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - instr_readdata=0, data_readdata=0, latency counter=0.
  - clk_enable=0 while reset is high.
  - Reset mid-access aborts immediately; any in-flight read data is discarded.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, RELEASE.
- IDLE:
  - data_read|data_write -> D_REQ; else instr_req -> I_REQ; else stay.
  - clk_enable = 1 only when no request is present (combinational from state and request inputs).
- D_REQ:
  - Drive mem_address=data_address.
  - Write: mem_write=1, mem_writedata=data_writedata.
  - Read: mem_read=1.
  - If data_read and data_write are both high, treat as a write; data_readdata is unchanged.
  - Hold strobes while mem_waitrequest=1.
  - On acceptance: read -> D_WAIT with counter=READ_LATENCY; write -> I_REQ if instr_req, else RELEASE.
- D_WAIT:
  - Strobes low; counter decrements each cycle.
  - In the last cycle (counter=1), capture mem_readdata into data_readdata.
  - Then -> I_REQ if instr_req, else RELEASE.
- I_REQ:
  - mem_address=instr_address, mem_read=1; hold while mem_waitrequest=1.
  - On acceptance -> I_WAIT with counter=READ_LATENCY.
- I_WAIT: same as D_WAIT, capturing into instr_readdata, then -> RELEASE.
- RELEASE: clk_enable=1 for exactly one cycle, strobes low, -> IDLE.
- Output rules:
  - clk_enable=0 in D_REQ, D_WAIT, I_REQ, I_WAIT, and in IDLE while a request is present.
  - mem_read and mem_write are never high together.
  - Strobes are high only in D_REQ and I_REQ.
  - mem_address and mem_writedata hold their last values when idle.
- Request changes while clk_enable=0 are a CPU protocol violation: inputs are sampled live, no latching.
- Latency with READ_LATENCY=1, no waitrequest, counted as RELEASE cycle after the IDLE cycle that sees the request:
  - fetch only: +3.
  - write+fetch: +4.
  - read+fetch: +5.
  - Each waitrequest cycle adds 1.
  - Each extra latency cycle adds 1 per read.

Test Plan:
- Reset check: assert reset mid-D_WAIT -> same-cycle mem_read=0, clk_enable=0, both readdata ports 0; after release, state=IDLE, and clk_enable=1 with no requests.
- Fetch only: instr_req=1, instr_address=0xBFC00000, memory returns 0x24020005 -> one mem_read at 0xBFC00000; instr_readdata=0x24020005; clk_enable pulses high exactly 3 cycles after the request.
- Write then fetch: data_write=1 to 0x00000010 with 0xDEADBEEF, plus instr_req at 0xBFC00004 -> mem_write precedes mem_read; memory word 0x10=0xDEADBEEF; clk_enable pulse at +4; data_readdata unchanged.
- Read then fetch: data_read at 0x10 (holds 0xDEADBEEF), plus fetch -> data_readdata=0xDEADBEEF, instr_readdata correct; pulse at +5; strobes never overlap.
- Waitrequest plus latency: READ_LATENCY=3, waitrequest high 2 cycles on the fetch -> mem_read and mem_address held for 3 cycles; capture occurs on the 3rd cycle after acceptance; pulse at +7.
- Both strobes high: data_read=1 and data_write=1 -> only mem_write is issued; data_readdata retains its prior value.
